// File: rtl/montgomery_exp_pkg.sv
// Shared RSA definitions: operand width, exponent-length width, multiplier
// digit size and the exponentiation controller state encoding.
package montgomery_exp_pkg;

    localparam int N_BITS    = 1024;
    localparam int ELEN_W    = 11;
    // Multiplier bits consumed per clock; one multiply takes N_BITS/MM_DIGITS + 1 cycles.
    localparam int MM_DIGITS = 64;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        NEXT_BIT,
        FIN_START,
        FIN_WAIT,
        DONE
    } state_t;

    function automatic logic [ELEN_W-1:0] clamp_len(input logic [ELEN_W-1:0] len);
        return (len > ELEN_W'(N_BITS)) ? ELEN_W'(N_BITS) : len;
    endfunction

endpackage

// File: rtl/montgomery.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-N mod M, MM_DIGITS bits per clock.
// Requires a < M, b < M (b = 1 also allowed) and M odd.
module montgomery
    import montgomery_exp_pkg::*;
#(
    parameter int N = N_BITS
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int STEPS = N / MM_DIGITS;
    localparam int CW    = $clog2(STEPS);

    logic           run_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q, b_q, m_q, result_q;
    logic [N+1:0]   acc_q, acc_d;
    logic [N-1:0]   red_d;
    logic           done_q;

    // Accumulator stays below 2M, so acc + b + M fits in N+2 bits.
    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < MM_DIGITS; j++) begin
            if (a_q[j]) acc_d = acc_d + {2'b00, b_q};
            if (acc_d[0]) acc_d = acc_d + {2'b00, m_q};
            acc_d = acc_d >> 1;
        end
        red_d = (acc_d >= {2'b00, m_q}) ? N'(acc_d - {2'b00, m_q}) : N'(acc_d);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!run_q) begin
                if (start) begin
                    run_q <= 1'b1;
                    cnt_q <= '0;
                    a_q   <= in_a;
                    b_q   <= in_b;
                    m_q   <= in_m;
                    acc_q <= '0;
                end
            end else begin
                acc_q <= acc_d;
                a_q   <= a_q >> MM_DIGITS;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    run_q    <= 1'b0;
                    result_q <= red_d;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: rtl/montgomery_exp.sv
// Left-to-right binary modular exponentiation around one time-shared
// Montgomery multiplier; the result is converted back to normal form.
module montgomery_exp
    import montgomery_exp_pkg::*;
#(
    parameter int N = N_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N-1:0]      in_x_mont,
    input  logic [N-1:0]      in_r_mod_m,
    input  logic [N-1:0]      in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [N-1:0]      in_m,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result
);

    state_t            state_q, state_d;
    logic [N-1:0]      x_q, e_q, m_q, a_q, result_q;
    logic [ELEN_W-1:0] i_q, t_in;
    logic [N-1:0]      mm_b, mm_result;
    logic              mm_start, mm_done;

    assign t_in = clamp_len(in_e_len);

    // Operand b depends only on the registered state, so it is stable from
    // the START cycle until the multiplier reports done.
    always_comb begin
        state_d = state_q;
        mm_b    = a_q;
        case (state_q)
            IDLE:      if (start) state_d = LOAD;
            LOAD:      state_d = (t_in != '0) ? SQ_START : FIN_START;
            SQ_START:  state_d = SQ_WAIT;
            SQ_WAIT:   if (mm_done) state_d = e_q[N-1] ? MUL_START : NEXT_BIT;
            MUL_START: begin
                mm_b    = x_q;
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                mm_b = x_q;
                if (mm_done) state_d = NEXT_BIT;
            end
            NEXT_BIT:  state_d = (i_q == '0) ? FIN_START : SQ_START;
            FIN_START: begin
                mm_b    = N'(1);
                state_d = FIN_WAIT;
            end
            FIN_WAIT: begin
                mm_b = N'(1);
                if (mm_done) state_d = DONE;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    x_q <= in_x_mont;
                    m_q <= in_m;
                    a_q <= in_r_mod_m;
                    // Align exponent bit t-1 to the MSB; NEXT_BIT shifts the next bit up.
                    e_q <= in_e << (ELEN_W'(N) - t_in);
                    i_q <= t_in - ELEN_W'(1);
                end
                SQ_WAIT, MUL_WAIT: if (mm_done) a_q <= mm_result;
                NEXT_BIT: begin
                    i_q <= i_q - ELEN_W'(1);
                    e_q <= e_q << 1;
                end
                FIN_WAIT: if (mm_done) result_q <= mm_result;
                default: ;
            endcase
        end
    end

    assign mm_start = (state_q == SQ_START) || (state_q == MUL_START) || (state_q == FIN_START);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = result_q;

    montgomery #(.N(N)) u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start),
        .in_a   (a_q),
        .in_b   (mm_b),
        .in_m   (m_q),
        .result (mm_result),
        .done   (mm_done)
    );

endmodule

// File: tb/tb_montgomery_exp.sv
// Scoreboarded bench for montgomery_exp: plain modular-arithmetic reference,
// latency / multiplication-count checks, re-pulsed start and reset abort.
module tb_montgomery_exp;
    import montgomery_exp_pkg::*;

    localparam int N      = 1024;
    localparam int MM_LAT = 17;   // mm_start sample to mm_done, inclusive

    logic              clk;
    logic              resetn;
    logic              start;
    logic [N-1:0]      in_x_mont, in_r_mod_m, in_e, in_m;
    logic [ELEN_W-1:0] in_e_len;
    logic              busy, done;
    logic [N-1:0]      result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int mm_cnt = 0;
    logic [N-1:0] exp_q[$];

    montgomery_exp #(.N(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_x_mont  (in_x_mont),
        .in_r_mod_m (in_r_mod_m),
        .in_e       (in_e),
        .in_e_len   (in_e_len),
        .in_m       (in_m),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got(lo128)=%0h exp(lo128)=%0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (dut.mm_start) mm_cnt++;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", result, exp_q.pop_front());
        end
    end

    function automatic logic [N-1:0] ref_exp(input logic [N-1:0] x, input logic [N-1:0] e,
                                             input int t, input logic [N-1:0] m);
        logic [2*N-1:0] r, wm, wx;
        wm = {{N{1'b0}}, m};
        wx = {{N{1'b0}}, x};
        r  = {{(2*N-1){1'b0}}, 1'b1} % wm;
        for (int i = t - 1; i >= 0; i--) begin
            r = (r * r) % wm;
            if (e[i]) r = (r * wx) % wm;
        end
        return r[N-1:0];
    endfunction

    task automatic drive_inputs(input logic [N-1:0] x, input logic [N-1:0] e,
                                input logic [ELEN_W-1:0] e_len, input logic [N-1:0] m);
        logic [2*N-1:0] wm, xr, rr;
        wm = {{N{1'b0}}, m};
        xr = {x, {N{1'b0}}};
        rr = {{(N-1){1'b0}}, 1'b1, {N{1'b0}}};
        in_x_mont  = N'(xr % wm);
        in_r_mod_m = N'(rr % wm);
        in_e       = e;
        in_e_len   = e_len;
        in_m       = m;
    endtask

    // driver: one exponentiation, optional extra start pulse at cycle repulse_at
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] e,
                          input logic [ELEN_W-1:0] e_len, input logic [N-1:0] m,
                          input int repulse_at, input string tag);
        int t, nmul, exp_lat, cyc, mm0, dn0;
        bit seen;
        t    = (e_len > 11'd1024) ? 1024 : int'(e_len);
        nmul = t + 1;
        for (int i = 0; i < t; i++) if (e[i]) nmul++;
        exp_lat = 2 + t + nmul * (1 + MM_LAT);
        @(negedge clk);
        drive_inputs(x, e, e_len, m);
        exp_q.push_back(ref_exp(x, e, t, m));
        mm0   = mm_cnt;
        dn0   = done_cnt;
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < exp_lat + 100) begin
            @(negedge clk);
            cyc++;
            start = (repulse_at != 0 && cyc == repulse_at);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 0, 1);
            exp_q.delete();
        end else begin
            chk({tag, "_latency"}, N'(cyc), N'(exp_lat));
        end
        @(negedge clk);
        chk({tag, "_mm_count"}, N'(mm_cnt - mm0), N'(nmul));
        chk({tag, "_done_count"}, N'(done_cnt - dn0), N'(1));
        chk({tag, "_busy_after"}, N'(busy), N'(0));
    endtask

    task automatic abort_in_mul_wait();
        int cyc, dn0;
        bit reached;
        @(negedge clk);
        drive_inputs(N'(7), N'(3), 11'd2, N'(15));
        start   = 1'b1;
        cyc     = 0;
        reached = 1'b0;
        while (!reached && cyc < 500) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (dut.state_q == MUL_WAIT) reached = 1'b1;
        end
        chk("abort_reached_mul_wait", N'(reached), N'(1));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_state", N'(dut.state_q), N'(IDLE));
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_done", N'(done), N'(0));
        dn0 = done_cnt;
        repeat (100) @(negedge clk);
        chk("abort_no_done", N'(done_cnt - dn0), N'(0));
    endtask

    initial begin
        logic [N-1:0] m, x, e;
        logic [ELEN_W-1:0] len;
        start      = 1'b0;
        in_x_mont  = '0;
        in_r_mod_m = '0;
        in_e       = '0;
        in_e_len   = '0;
        in_m       = '0;
        do_reset(3);

        chk("reset_busy", N'(busy), N'(0));
        chk("reset_done", N'(done), N'(0));
        chk("reset_result", result, N'(0));
        chk("reset_state", N'(dut.state_q), N'(IDLE));
        chk("reset_mm_start", N'(dut.mm_start), N'(0));

        run_op(N'(2), N'(10), 11'd4, N'(15), 0, "x2_e10");
        chk("x2_e10_const", result, N'(4));
        run_op(N'(7), N'(3), 11'd2, N'(15), 0, "x7_e3");
        run_op(N'(9), N'($urandom), 11'd0, N'(15), 0, "t0_m15");
        chk("t0_m15_const", result, N'(1));
        run_op(N'(0), N'($urandom), 11'd0, N'(1), 0, "t0_m1");
        chk("t0_m1_const", result, N'(0));
        // second squaring of the x=2 run sits in SQ_WAIT at cycle 45
        run_op(N'(2), N'(10), 11'd4, N'(15), 45, "repulse");
        chk("repulse_const", result, N'(4));
        abort_in_mul_wait();
        run_op(N'(7), N'(3), 11'd2, N'(15), 0, "after_abort");

        for (int k = 0; k < 3; k++) begin
            m   = N'($urandom_range(65535, 3) | 1);
            x   = N'($urandom_range(int'(m[15:0]) - 1, 0));
            e   = N'($urandom);
            len = ELEN_W'($urandom_range(24, 1));
            run_op(x, e, len, m, 0, "small_rand");
        end

        for (int w = 0; w < N / 32; w++) begin
            m[w*32 +: 32] = $urandom;
            x[w*32 +: 32] = $urandom;
            e[w*32 +: 32] = $urandom;
        end
        m[N-1] = 1'b1;
        m[0]   = 1'b1;
        x      = x % m;
        run_op(x, e, 11'd1024, m, 0, "full_1024");

        e        = '0;
        e[31:0]  = $urandom;
        e[N-1]   = 1'b1;
        run_op(N'(2), e, 11'd2047, N'(15), 0, "clamp_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
